// File: rtl/count01_sched.sv
// count01_sched
//   Shares one serial "01"-pattern counter among N requesters. An idle
//   scheduler picks the next requester round-robin, loads its W-bit word,
//   shifts it MSB-first through a 0->1 transition detector and returns the
//   number of detections with the requester ID on a valid/ready port.
//
// Ports
//   clk        : clock, all state updates on posedge
//   rst        : asynchronous, active-high reset
//   req[N]     : level request per requester, held until its gnt
//   data[N*W]  : word of requester i on bits [i*W +: W]
//   gnt[N]     : one-hot, registered, single-cycle acceptance pulse
//   busy       : high while a job is shifting or awaiting acceptance
//   res_valid  : result available
//   res_ready  : consumer accepts the result
//   res_id     : requester the result belongs to
//   res_count  : number of 0->1 transitions in the word
module count01_sched #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int CW  = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data,
  output logic [N-1:0]   gnt,
  output logic           busy,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [IDW-1:0] res_id,
  output logic [CW-1:0]  res_count
);

  localparam int BW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [IDW-1:0] r_ptr;
  logic [W-1:0]   r_sr;
  logic [BW-1:0]  r_bitcnt;
  logic [CW-1:0]  r_cnt;
  logic           r_prev;
  logic [N-1:0]   r_gnt;
  logic           r_vld;
  logic [IDW-1:0] r_id;
  logic [CW-1:0]  r_res_count;

  logic           w_found;
  logic [IDW-1:0] w_sel;
  logic [IDW-1:0] w_ptr_nxt;
  logic [N-1:0]   w_onehot;
  logic [W-1:0]   w_word;
  logic           w_bit;
  logic           w_last;

  // Round-robin pick: first set request scanning upward from the pointer,
  // wrapping modulo N (N need not be a power of two).
  always_comb begin : arb
    logic [IDW:0] v_idx;
    w_found = 1'b0;
    w_sel   = '0;
    v_idx   = '0;
    for (int k = 0; k < N; k++) begin
      v_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (v_idx >= (IDW+1)'(N))
        v_idx = v_idx - (IDW+1)'(N);
      if (!w_found && req[v_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = v_idx[IDW-1:0];
      end
    end
  end

  always_comb begin : ptr_next
    logic [IDW:0] v_nxt;
    v_nxt = {1'b0, w_sel} + (IDW+1)'(1);
    if (v_nxt >= (IDW+1)'(N))
      v_nxt = '0;
    w_ptr_nxt = v_nxt[IDW-1:0];
  end

  always_comb begin
    w_onehot = '0;
    w_word   = '0;
    for (int i = 0; i < N; i++) begin
      if (w_sel == IDW'(i)) begin
        w_onehot[i] = 1'b1;
        w_word      = data[i*W +: W];
      end
    end
  end

  assign w_bit  = r_sr[W-1];
  // W bit-consuming edges, then one edge that publishes the settled count.
  assign w_last = (r_bitcnt == BW'(W));

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found)   w_state_nxt = SHIFT;
      SHIFT:   if (w_last)    w_state_nxt = DONE;
      DONE:    if (res_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (r_state == SHIFT) || (r_state == DONE);
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_sr        <= '0;
      r_bitcnt    <= '0;
      r_cnt       <= '0;
      r_prev      <= 1'b1;
      r_gnt       <= '0;
      r_vld       <= 1'b0;
      r_id        <= '0;
      r_res_count <= '0;
    end else begin
      r_gnt <= '0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_sr        <= w_word;
            r_gnt       <= w_onehot;
            r_id        <= w_sel;
            r_cnt       <= '0;
            r_res_count <= '0;
            // prev=1 so the first bit can never register as a 0->1 edge
            r_prev      <= 1'b1;
            r_bitcnt    <= '0;
            r_ptr       <= w_ptr_nxt;
          end
        end
        SHIFT: begin
          if (!w_last) begin
            r_sr     <= {r_sr[W-2:0], 1'b0};
            r_prev   <= w_bit;
            r_bitcnt <= r_bitcnt + BW'(1);
            if (w_bit && !r_prev)
              r_cnt <= r_cnt + CW'(1);
          end else begin
            r_res_count <= r_cnt;
            r_vld       <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready)
            r_vld <= 1'b0;
        end
        default: r_vld <= 1'b0;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign res_valid = r_vld;
  assign res_id    = r_id;
  assign res_count = r_res_count;

endmodule

// File: tb/tb_count01_sched.sv
module tb_count01_sched;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int CW  = 4;
  localparam int IDW = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           res_valid;
  logic           res_ready;
  logic [IDW-1:0] res_id;
  logic [CW-1:0]  res_count;

  int n_pass  = 0;
  int n_total = 0;

  count01_sched #(.N(N), .W(W), .CW(CW), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_count (res_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic wait_gnt(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (gnt == '0 && cyc < 40);
  endtask

  // Called at the negedge right after the grant was seen; res_ready must be 1.
  task automatic finish_job(input int idx, input int exp_cnt, input string tag);
    int k;
    k = 0;
    while (!res_valid && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) chk({tag, "_gnt_pulse"}, 32'(gnt), 0);
    end
    chk({tag, "_latency"}, k, W + 1);
    chk({tag, "_id"}, 32'(res_id), idx);
    chk({tag, "_count"}, 32'(res_count), exp_cnt);
    @(negedge clk);
    chk({tag, "_vld_clr"}, 32'(res_valid), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic run_job(input int idx, input logic [W-1:0] word, input int exp_cnt,
                         input string tag);
    int c;
    data[idx*W +: W] = word;
    req = '0;
    req[idx] = 1'b1;
    wait_gnt(c);
    chk({tag, "_gnt"}, 32'(gnt), 32'(1) << idx);
    req = '0;
    finish_job(idx, exp_cnt, tag);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int c, cyc, ng, last, tprev, gidx, cnt_g2;
    int exp_cnt[N];

    rst = 1'b1;
    req = '0;
    data = '0;
    res_ready = 1'b1;
    #12;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_vld", 32'(res_valid), 0);
    chk("rst_id", 32'(res_id), 0);
    chk("rst_count", 32'(res_count), 0);
    @(negedge clk);
    rst = 1'b0;

    // single jobs on requester 0
    run_job(0, 8'b01010101, 4, "j55");
    run_job(0, 8'b00000000, 0, "j00");
    run_job(0, 8'b11111111, 0, "jff");
    run_job(0, 8'b00001111, 1, "j0f");
    run_job(0, 8'b10101010, 3, "jaa");

    // round-robin with all requests held
    reset_pulse();
    data[0*W +: W] = 8'b01010101; exp_cnt[0] = 4;
    data[1*W +: W] = 8'b00001111; exp_cnt[1] = 1;
    data[2*W +: W] = 8'b10101010; exp_cnt[2] = 3;
    data[3*W +: W] = 8'b11111111; exp_cnt[3] = 0;
    req = 4'b1111;
    cyc = 0; ng = 0; last = 0; tprev = 0;
    while (ng < 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (gnt != '0) begin
        gidx = 0;
        for (int i = 0; i < N; i++) if (gnt[i]) gidx = i;
        chk("rr_order", gidx, ng % N);
        if (ng > 0) chk("rr_gap", cyc - tprev, W + 3);
        tprev = cyc;
        last = gidx;
        ng++;
        if (ng == 5) req = '0;
      end
      if (res_valid) begin
        chk("rr_id", 32'(res_id), last);
        chk("rr_count", 32'(res_count), exp_cnt[last]);
      end
    end
    chk("rr_ngrants", ng, 5);
    finish_job(0, 4, "rr_last");

    // back-pressure in DONE
    res_ready = 1'b0;
    data[0*W +: W] = 8'b00110011;
    req = 4'b0001;
    wait_gnt(c);
    chk("bp_gnt", 32'(gnt), 1);
    req = '0;
    c = 0;
    while (!res_valid && c < 40) begin
      @(negedge clk);
      c++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_vld", 32'(res_valid), 1);
      chk("bp_id", 32'(res_id), 0);
      chk("bp_count", 32'(res_count), 2);
      chk("bp_busy", 32'(busy), 1);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_vld_clr", 32'(res_valid), 0);
    chk("bp_idle", 32'(busy), 0);
    chk("bp_count_held", 32'(res_count), 2);

    // async reset in SHIFT cycle 4 of a job for requester 1
    data[1*W +: W] = 8'b01010101;
    req = 4'b0010;
    wait_gnt(c);
    chk("ar_gnt", 32'(gnt), 32'b0010);
    repeat (3) @(negedge clk);
    req = 4'b1010;
    rst = 1'b1;
    #1;
    chk("ar_gnt0", 32'(gnt), 0);
    chk("ar_busy0", 32'(busy), 0);
    chk("ar_vld0", 32'(res_valid), 0);
    chk("ar_id0", 32'(res_id), 0);
    chk("ar_count0", 32'(res_count), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_gnt(c);
    chk("ar_regrant", 32'(gnt), 32'b0010);
    chk("ar_no_result", 32'(res_valid), 0);
    req = 4'b1000;
    finish_job(1, 4, "ar_j1");
    wait_gnt(c);
    chk("ar_next", 32'(gnt), 32'b1000);
    req = '0;
    finish_job(3, 0, "ar_j3");

    // short request pulse while busy is ignored
    data[0*W +: W] = 8'b00001111;
    req = 4'b0001;
    wait_gnt(c);
    chk("pu_gnt", 32'(gnt), 1);
    req = '0;
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    cnt_g2 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt[2]) cnt_g2++;
      if (res_valid) chk("pu_count", 32'(res_count), 1);
    end
    chk("pu_no_gnt2", cnt_g2, 0);
    chk("pu_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
